sha256_padder: RTL and testbench



---
 rtl/sha256_padder.sv | 160 ++++++++++++++++
 tb/tb_sha256_padder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns a 32-bit big-endian word stream into padded
// 512-bit chunks emitted one word per beat. It appends the 0x80 marker, the
// zero fill and the 64-bit big-endian bit length.
module sha256_padder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic [2:0]  in_bytes,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_idx,
    output logic        out_first,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    // DATA forwards message words; PAD emits the marker/zero fill; LEN_HI and
    // LEN_LO emit the two halves of the bit length at indices 14 and 15.
    typedef enum logic [1:0] {DATA, PAD, LEN_HI, LEN_LO} state_t;

    state_t      state_q, state_d;
    logic [63:0] bits_q, bits_d;        // message bit count so far
    logic [3:0]  idx_q, idx_d;          // index the next emitted word will carry
    logic        first_q, first_d;      // next emitted word belongs to chunk 1
    logic        mark_q, mark_d;        // 0x80 marker still owed (final beat was full)

    logic [31:0] out_word_q, out_word_d;
    logic [3:0]  out_idx_q, out_idx_d;
    logic        out_first_q, out_first_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;

    logic        adv;                   // output register may take a new word
    logic [2:0]  last_n;                // final-beat byte count, clamped to 4
    logic        emit;
    logic [31:0] emit_word;
    logic        emit_last;

    assign adv       = !out_valid_q || out_ready;
    assign last_n    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign in_ready  = !rst && (state_q == DATA) && adv;
    assign out_valid = out_valid_q && !rst;
    assign out_word  = out_word_q;
    assign out_idx   = out_idx_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

    // Next-state, padding sequence and output-register load.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        bits_d      = bits_q;
        idx_d       = idx_q;
        first_d     = first_q;
        mark_d      = mark_q;
        out_word_d  = out_word_q;
        out_idx_d   = out_idx_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;
        emit        = 1'b0;
        emit_word   = 32'h0;
        emit_last   = 1'b0;

        if (adv) begin
            unique case (state_q)
                DATA: begin
                    if (in_valid) begin
                        emit = 1'b1;
                        if (!in_last) begin
                            emit_word = in_word;
                            bits_d    = bits_q + 64'd32;
                        end else begin
                            bits_d = bits_q + 64'({last_n, 3'b000});
                            unique case (last_n)
                                3'd0:    emit_word = 32'h8000_0000;
                                3'd1:    emit_word = {in_word[31:24], 24'h80_0000};
                                3'd2:    emit_word = {in_word[31:16], 16'h8000};
                                3'd3:    emit_word = {in_word[31:8], 8'h80};
                                default: emit_word = in_word;
                            endcase
                            if (last_n == 3'd4) begin
                                mark_d  = 1'b1;
                                state_d = PAD;
                            end else begin
                                state_d = (idx_q == 4'd13) ? LEN_HI : PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    emit      = 1'b1;
                    emit_word = mark_q ? 32'h8000_0000 : 32'h0;
                    mark_d    = 1'b0;
                    state_d   = (idx_q == 4'd13) ? LEN_HI : PAD;
                end
                LEN_HI: begin
                    emit      = 1'b1;
                    emit_word = bits_q[63:32];
                    state_d   = LEN_LO;
                end
                default: begin // LEN_LO
                    emit      = 1'b1;
                    emit_word = bits_q[31:0];
                    emit_last = 1'b1;
                    bits_d    = 64'h0;
                    state_d   = DATA;
                end
            endcase
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_word_d  = emit_word;
            out_idx_d   = idx_q;
            out_first_d = first_q;
            out_last_d  = emit_last;
            idx_d       = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
                first_d = 1'b0;
            end
            if (emit_last) begin
                first_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= DATA;
            bits_q      <= 64'h0;
            idx_q       <= 4'd0;
            first_q     <= 1'b1;
            mark_q      <= 1'b0;
            out_word_q  <= 32'h0;
            out_idx_q   <= 4'd0;
            out_first_q <= 1'b1;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_q      <= bits_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            mark_q      <= mark_d;
            out_word_q  <= out_word_d;
            out_idx_q   <= out_idx_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: random messages are padded by a
// byte-level reference model and compared word by word against the DUT.
module tb_sha256_padder;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [31:0] w;
        logic [3:0]  idx;
        logic        first;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_word = '0;
    logic [2:0]  in_bytes = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_word;
    logic [3:0]  out_idx;
    logic        out_first;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        throttle = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    logic [3:0]  prev_idx = '0;

    sha256_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_first (out_first),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", tag);
    endtask

    // Reference: byte-level SHA-256 padding, then split into words.
    task automatic model_msg(input bytes_t msg);
        bytes_t      p;
        logic [63:0] bl;
        int          nw;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++) begin
            exp_t e;
            e.w     = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            e.idx   = 4'(i % 16);
            e.first = (i < 16);
            e.last  = (i == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic bytes_t rand_msg(input int n);
        bytes_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    // Drive one beat; called at negedge+2, returns at negedge+2 after it transfers.
    task automatic send_beat(input logic [31:0] w, input logic [2:0] n, input logic last);
        int t;
        in_word  = w;
        in_bytes = n;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 2000) bound_fail("in_ready_timeout");
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        in_word  = $urandom;
        if (throttle && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            #2;
        end
    endtask

    // Unused low byte lanes of the final beat carry garbage to exercise masking.
    task automatic send_msg(input bytes_t msg, input logic [31:0] garbage);
        int n, nfull, r;
        logic [31:0] w;
        model_msg(msg);
        n     = msg.size();
        nfull = n / 4;
        r     = n % 4;
        if (n == 0) begin
            send_beat(garbage, 3'd0, 1'b1);
        end else begin
            for (int i = 0; i < nfull; i++) begin
                w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
                send_beat(w, (r == 0 && i == nfull - 1) ? 3'd4 : 3'($urandom_range(0, 7)),
                          (r == 0 && i == nfull - 1));
            end
            if (r != 0) begin
                w = garbage;
                for (int b = 0; b < r; b++) w[31-8*b -: 8] = msg[4*nfull+b];
                send_beat(w, 3'(r), 1'b1);
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 5000) bound_fail("drain_timeout");
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: drives out_ready, then checks transfers and stall rules.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_word", 64'(out_word), 64'(prev_word));
                    check("hold_idx", 64'(out_idx), 64'(prev_idx));
                end
                if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h with nothing expected", out_word);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("word", 64'(out_word), 64'(e.w));
                        check("idx", 64'(out_idx), 64'(e.idx));
                        check("first", 64'(out_first), 64'(e.first));
                        check("last", 64'(out_last), 64'(e.last));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = out_word;
                prev_idx   = out_idx;
            end
        end
    end

    always @(posedge clk) begin
        if (in_valid && in_last) assert (in_bytes <= 3'd4) else $error("illegal in_bytes");
    end

    initial begin
        bytes_t m;
        int t;

        // Reset behaviour.
        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("rst_out_word", 64'(out_word), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_first", 64'(out_first), 64'd1);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_valid_after", 64'(out_valid), 64'd0);
        check("rst_in_ready_after", 64'(in_ready), 64'd1);

        // Directed messages, unthrottled.
        m = {};
        send_msg(m, $urandom);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 32'h0);
        send_msg(rand_msg(55), $urandom);
        send_msg(rand_msg(56), $urandom);
        send_msg(rand_msg(64), $urandom);
        m = rand_msg(130);
        send_msg(m, 32'hA5A5_A5A5);
        wait_drain();

        // Same 130-byte message with random output backpressure.
        throttle = 1'b1;
        send_msg(m, 32'hA5A5_A5A5);
        wait_drain();

        // Random lengths under backpressure, sent back to back.
        for (int k = 0; k < 10; k++) send_msg(rand_msg($urandom_range(0, 200)), $urandom);
        wait_drain();

        // Reset during PAD of message A, then "abc".
        throttle = 1'b0;
        send_msg(rand_msg(20), $urandom);
        t = 0;
        while (exp_q.size() > 8 && t < 1000) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 1000) bound_fail("mid_pad_timeout");
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("midrst_idx", 64'(out_idx), 64'd0);
        check("midrst_first", 64'(out_first), 64'd1);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 32'h0);
        wait_drain();
        repeat (30) @(negedge clk);
        #2;
        check("final_idle_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
